control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit single-bus CPU datapath. It steps through fetch (T0–T2) and execute (T3–T7) for every instruction and drives the datapath's register-in/out strobes, ALU operation code, bus source selects and memory strobes. It holds in wait states on the memory handshake and stops on HALT, a `stop` request, or `clear`.

---
 rtl/control_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit single-bus CPU.
// Steps fetch (T0-T2) and execute (T3-T7), decoding strobes from the step and IR.
module control_sequencer #(
    parameter int unsigned OPW = 5,
    parameter int unsigned RSW = 4
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    input  logic           stop,
    output logic           PCout,
    output logic           PCin,
    output logic           IncPC,
    output logic           MARin,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           HIin,
    output logic           LOin,
    output logic           Cout,
    output logic           Read,
    output logic           Write,
    output logic           reg_out_en,
    output logic [RSW-1:0] reg_out_sel,
    output logic           reg_in_en,
    output logic [RSW-1:0] reg_in_sel,
    output logic [3:0]     alu_op,
    output logic           run,
    output logic           illegal
);

    typedef enum logic [3:0] {
        StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } step_e;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpSt   = 5'b00001;
    localparam logic [4:0] OpAdd  = 5'b00010;
    localparam logic [4:0] OpSub  = 5'b00011;
    localparam logic [4:0] OpAnd  = 5'b00100;
    localparam logic [4:0] OpOr   = 5'b00101;
    localparam logic [4:0] OpShr  = 5'b00110;
    localparam logic [4:0] OpShl  = 5'b00111;
    localparam logic [4:0] OpAddi = 5'b01000;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNop  = 5'b11000;
    localparam logic [4:0] OpHalt = 5'b11001;

    step_e            r_step;
    step_e            w_boundary;
    logic [OPW-1:0]   w_op;
    logic [RSW-1:0]   w_ra;
    logic [RSW-1:0]   w_rb;
    logic [RSW-1:0]   w_rc;
    logic             w_is_alu;
    logic             w_is_muldiv;
    logic             w_is_addi;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_is_nop;
    logic             w_is_halt;
    logic             w_is_illegal;
    logic [3:0]       w_alu_code;
    logic             w_unused_ir;

    assign w_op = ir[31 -: OPW];
    assign w_ra = ir[26 -: RSW];
    assign w_rb = ir[22 -: RSW];
    assign w_rc = ir[18 -: RSW];
    assign w_unused_ir = ^ir[14:0];

    assign w_is_alu     = (w_op >= OpAdd) && (w_op <= OpShl);
    assign w_is_muldiv  = (w_op == OpMul) || (w_op == OpDiv);
    assign w_is_addi    = (w_op == OpAddi);
    assign w_is_ld      = (w_op == OpLd);
    assign w_is_st      = (w_op == OpSt);
    assign w_is_nop     = (w_op == OpNop);
    assign w_is_halt    = (w_op == OpHalt);
    assign w_is_illegal = !(w_is_alu || w_is_muldiv || w_is_addi || w_is_ld || w_is_st ||
                            w_is_nop || w_is_halt);

    // Leaving the last execute state: a pending stop request diverts to HALT.
    assign w_boundary = stop ? StHalt : StT0;

    // ALU function code for the opcode currently in IR.
    always_comb begin
        w_alu_code = 4'd0;
        case (w_op)
            OpSub:   w_alu_code = 4'd1;
            OpAnd:   w_alu_code = 4'd2;
            OpOr:    w_alu_code = 4'd3;
            OpShr:   w_alu_code = 4'd4;
            OpShl:   w_alu_code = 4'd5;
            OpMul:   w_alu_code = 4'd6;
            OpDiv:   w_alu_code = 4'd7;
            default: w_alu_code = 4'd0;
        endcase
    end

    // Step register: clear wins from any state; wait states hold until mem_ready.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_step <= StT0;
        end else begin
            case (r_step)
                StT0: r_step <= StT1;
                StT1: if (mem_ready) r_step <= StT2;
                StT2: r_step <= StT3;
                StT3: begin
                    if (w_is_halt) begin
                        r_step <= StHalt;
                    end else if (w_is_nop || w_is_illegal) begin
                        r_step <= w_boundary;
                    end else begin
                        r_step <= StT4;
                    end
                end
                StT4: r_step <= StT5;
                StT5: r_step <= (w_is_alu || w_is_addi) ? w_boundary : StT6;
                StT6: begin
                    if (w_is_muldiv) begin
                        r_step <= w_boundary;
                    end else if (w_is_ld) begin
                        if (mem_ready) r_step <= StT7;
                    end else if (w_is_st) begin
                        r_step <= StT7;
                    end else begin
                        r_step <= StT0;
                    end
                end
                StT7: begin
                    if (w_is_ld || mem_ready) r_step <= w_boundary;
                end
                StHalt: r_step <= StHalt;
                default: r_step <= StT0;
            endcase
        end
    end

    // Strobe decode from step and IR; everything is masked while clear is high.
    always_comb begin
        PCout       = 1'b0;
        PCin        = 1'b0;
        IncPC       = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        Cout        = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = '0;
        reg_in_en   = 1'b0;
        reg_in_sel  = '0;
        alu_op      = 4'd0;
        illegal     = 1'b0;
        run         = clear || (r_step != StHalt);
        if (!clear) begin
            case (r_step)
                StT0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
                StT1: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                StT2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                StT3: begin
                    if (w_is_alu || w_is_muldiv || w_is_addi || w_is_ld || w_is_st) begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = w_rb;
                        Yin         = 1'b1;
                    end
                    illegal = w_is_illegal;
                end
                StT4: begin
                    Zin = 1'b1;
                    if (w_is_alu || w_is_muldiv) begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = w_rc;
                        alu_op      = w_alu_code;
                    end else begin
                        Cout = 1'b1;
                    end
                end
                StT5: begin
                    Zlowout = 1'b1;
                    if (w_is_alu || w_is_addi) begin
                        reg_in_en  = 1'b1;
                        reg_in_sel = w_ra;
                    end else if (w_is_muldiv) begin
                        LOin = 1'b1;
                    end else begin
                        MARin = 1'b1;
                    end
                end
                StT6: begin
                    if (w_is_muldiv) begin
                        Zhighout = 1'b1;
                        HIin     = 1'b1;
                    end else if (w_is_ld) begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end else if (w_is_st) begin
                        reg_out_en  = 1'b1;
                        reg_out_sel = w_ra;
                        MDRin       = 1'b1;
                    end
                end
                StT7: begin
                    if (w_is_ld) begin
                        MDRout     = 1'b1;
                        reg_in_en  = 1'b1;
                        reg_in_sel = w_ra;
                    end else if (w_is_st) begin
                        Write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-cycle comparison of all outputs against a micro-step
// table derived from the instruction set, with randomized waits, fields and stop.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout;
    logic HIin, LOin, Cout, Read, Write, reg_out_en, reg_in_en, run, illegal;
    logic [3:0] reg_out_sel, reg_in_sel, alu_op;
    logic [31:0] obs;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] M_PCOUT = 32'h1 << 31;
    localparam logic [31:0] M_PCIN  = 32'h1 << 30;
    localparam logic [31:0] M_INCPC = 32'h1 << 29;
    localparam logic [31:0] M_MARIN = 32'h1 << 28;
    localparam logic [31:0] M_MDRIN = 32'h1 << 27;
    localparam logic [31:0] M_MDROUT = 32'h1 << 26;
    localparam logic [31:0] M_IRIN  = 32'h1 << 25;
    localparam logic [31:0] M_YIN   = 32'h1 << 24;
    localparam logic [31:0] M_ZIN   = 32'h1 << 23;
    localparam logic [31:0] M_ZLO   = 32'h1 << 22;
    localparam logic [31:0] M_ZHI   = 32'h1 << 21;
    localparam logic [31:0] M_HIIN  = 32'h1 << 20;
    localparam logic [31:0] M_LOIN  = 32'h1 << 19;
    localparam logic [31:0] M_COUT  = 32'h1 << 18;
    localparam logic [31:0] M_READ  = 32'h1 << 17;
    localparam logic [31:0] M_WRITE = 32'h1 << 16;
    localparam logic [31:0] M_ROE   = 32'h1 << 15;
    localparam logic [31:0] M_RIE   = 32'h1 << 10;
    localparam logic [31:0] M_RUN   = 32'h1 << 1;
    localparam logic [31:0] M_ILL   = 32'h1;

    typedef struct {
        logic [31:0] v;
        bit          w;
    } step_t;

    step_t exp_q[$];

    control_sequencer #(.OPW(5), .RSW(4)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Cout(Cout), .Read(Read),
        .Write(Write), .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
        .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel), .alu_op(alu_op), .run(run),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout,
                  HIin, LOin, Cout, Read, Write, reg_out_en, reg_out_sel, reg_in_en,
                  reg_in_sel, alu_op, run, illegal};

    function automatic logic [31:0] ro(input logic [3:0] r);
        return M_ROE | ({28'd0, r} << 11);
    endfunction

    function automatic logic [31:0] ri(input logic [3:0] r);
        return M_RIE | ({28'd0, r} << 6);
    endfunction

    function automatic logic [31:0] alu(input int a);
        logic [31:0] t;
        t = a;
        return t << 2;
    endfunction

    function automatic void push(input logic [31:0] v, input bit w);
        step_t s;
        s.v = v | M_RUN;
        s.w = w;
        exp_q.push_back(s);
    endfunction

    // Expected cycle-by-cycle outputs of one instruction, from the opcode table.
    function automatic void build(input logic [31:0] instr);
        int op;
        logic [3:0] ra, rb, rc;
        op = int'(instr[31:27]);
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        exp_q.delete();
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0);
        push(M_ZLO | M_PCIN | M_READ | M_MDRIN, 1);
        push(M_MDROUT | M_IRIN, 0);
        if (op == 0 || op == 1 || op == 8) begin
            push(ro(rb) | M_YIN, 0);
            push(M_COUT | M_ZIN, 0);
            if (op == 8) begin
                push(M_ZLO | ri(ra), 0);
            end else begin
                push(M_ZLO | M_MARIN, 0);
                if (op == 0) begin
                    push(M_READ | M_MDRIN, 1);
                    push(M_MDROUT | ri(ra), 0);
                end else begin
                    push(ro(ra) | M_MDRIN, 0);
                    push(M_WRITE, 1);
                end
            end
        end else if ((op >= 2 && op <= 7) || op == 15 || op == 16) begin
            push(ro(rb) | M_YIN, 0);
            push(ro(rc) | alu(op == 15 ? 6 : op == 16 ? 7 : op - 2) | M_ZIN, 0);
            if (op <= 7) begin
                push(M_ZLO | ri(ra), 0);
            end else begin
                push(M_ZLO | M_LOIN, 0);
                push(M_ZHI | M_HIIN, 0);
            end
        end else if (op == 24 || op == 25) begin
            push(32'h0, 0);
        end else begin
            push(M_ILL, 0);
        end
    endfunction

    // Runs one instruction. nwait<0 picks random wait lengths; stop_at>=0 raises stop
    // from that step onward; rnd_stop toggles stop randomly except on the last step.
    task automatic run_instr(input logic [31:0] instr, input int nwait, input int stop_at,
                             input bit rnd_stop, input string tag);
        int n;
        int last;
        build(instr);
        ir = instr;
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (stop_at >= 0 && i >= stop_at) stop = 1'b1;
            else if (rnd_stop && i != last) stop = 1'($urandom_range(0, 1));
            else stop = 1'b0;
            n = exp_q[i].w ? (nwait < 0 ? int'($urandom_range(0, 3)) : nwait) : 0;
            for (int k = 0; k <= n; k++) begin
                mem_ready = exp_q[i].w ? (k == n) : 1'($urandom_range(0, 1));
                @(negedge clock);
                checks++;
                if (obs !== exp_q[i].v) begin
                    errors++;
                    $display("FAIL %s ir=%h step %0d wait %0d: got %h expected %h",
                             tag, instr, i, k, obs, exp_q[i].v);
                end
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic expect_halted(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            stop = 1'($urandom_range(0, 1));
            @(negedge clock);
            checks++;
            if (obs !== 32'h0) begin
                errors++;
                $display("FAIL %s halted cycle %0d: got %h expected %h", tag, c, obs, 32'h0);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear(input string tag);
        clear = 1'b1;
        stop = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== M_RUN) begin
            errors++;
            $display("FAIL %s during clear: got %h expected %h", tag, obs, M_RUN);
        end
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        mem_ready = 1'b1;
        stop = 1'b0;
        ir = 32'h0;
        @(posedge clock);
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (obs !== M_RUN) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", c, obs, M_RUN);
            end
            @(posedge clock);
            #1;
        end
        clear = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== (M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN)) begin
            errors++;
            $display("FAIL reset_t0: got %h expected %h", obs,
                     M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN);
        end
        @(posedge clock);
        #1;
        pulse_clear("reset_reclear");
    endtask

    task automatic test_alu_ops();
        run_instr(32'h10918000, 0, -1, 0, "add");
        run_instr(32'h1A2B8000, 0, -1, 0, "sub");
        run_instr(32'h3F4A0000, 0, -1, 0, "shl");
        run_instr(32'h44B10000, 0, -1, 0, "addi");
    endtask

    task automatic test_mem_wait();
        run_instr(32'h10918000, 3, -1, 0, "memwait_add");
        run_instr(32'h00900000, 2, -1, 0, "memwait_ld");
        run_instr(32'h0A900000, 3, -1, 0, "memwait_st");
    endtask

    task automatic test_ld_st_muldiv();
        run_instr(32'h00900000, 0, -1, 0, "ld");
        run_instr(32'h0D180000, 0, -1, 0, "st");
        run_instr(32'h78918000, 0, -1, 0, "mul");
        run_instr(32'h81A28000, 0, -1, 0, "div");
    endtask

    task automatic test_nop_illegal();
        run_instr(32'hC0000000, 0, -1, 0, "nop");
        run_instr(32'hF8000000, 0, -1, 0, "illegal");
        run_instr(32'h48000000, 0, -1, 0, "illegal_09");
    endtask

    task automatic test_halt_stop();
        run_instr(32'hC8000000, 0, -1, 0, "halt");
        expect_halted(12, "halt");
        pulse_clear("halt_clear");
        run_instr(32'h10918000, 0, 4, 0, "stop_add");
        expect_halted(5, "stop_add");
        pulse_clear("stop_clear");
        run_instr(32'hC8000000, 0, 3, 0, "halt_with_stop");
        expect_halted(4, "halt_with_stop");
        pulse_clear("halt_stop_clear");
        run_instr(32'h00900000, 1, 7, 0, "stop_ld");
        expect_halted(3, "stop_ld");
        pulse_clear("stop_ld_clear");
    endtask

    // Clear lands while a store is stalled in its write wait.
    task automatic test_clear_midstore();
        build(32'h0A900000);
        ir = 32'h0A900000;
        stop = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = (i == exp_q.size() - 1) ? 1'b0 : 1'b1;
            @(negedge clock);
            checks++;
            if (obs !== exp_q[i].v) begin
                errors++;
                $display("FAIL clear_midstore step %0d: got %h expected %h", i, obs, exp_q[i].v);
            end
            @(posedge clock);
            #1;
        end
        mem_ready = 1'b0;
        pulse_clear("clear_midstore");
        run_instr(32'h10918000, 0, -1, 0, "after_clear");
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr;
        for (int n = 0; n < 60; n++) begin
            instr = $urandom;
            if (instr[31:27] == 5'b11001) instr[31:27] = 5'b11000;
            run_instr(instr, -1, -1, 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mem_wait();
        test_ld_st_muldiv();
        test_nop_illegal();
        test_halt_stop();
        test_clear_midstore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
